// File: rtl/nios_system_de2_pio_switch_in_if.sv
// ---------------------------------------------------------------------------
// nios_system_de2_pio_switch_in_if
//
// Purpose:
//   Avalon-MM slave bus bundle for the switch/key input PIO. It carries the
//   word address, chip select, active-low write strobe, write data and the
//   registered read data returned by the slave.
//
// Signals:
//   address    [1:0]   word address of the selected register
//   chipselect         slave select
//   write_n            active-low write strobe (read when chipselect & write_n)
//   writedata  [31:0]  write data from the master
//   readdata   [31:0]  read data from the slave, valid one clock after a read
//
// Modports:
//   master  drives address/chipselect/write_n/writedata, samples readdata
//   slave   samples address/chipselect/write_n/writedata, drives readdata
// ---------------------------------------------------------------------------
interface nios_system_de2_pio_switch_in_if;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;

    modport master (
        output address,
        output chipselect,
        output write_n,
        output writedata,
        input  readdata
    );

    modport slave (
        input  address,
        input  chipselect,
        input  write_n,
        input  writedata,
        output readdata
    );
endinterface

// File: rtl/nios_system_de2_pio_switch_in.sv
// ---------------------------------------------------------------------------
// nios_system_de2_pio_switch_in
//
// Purpose:
//   Avalon-MM slave input PIO for the DE2 board switches and keys. Every raw
//   input bit passes through a two-flop synchronizer and a tick-based
//   debouncer. Debounced edges of the selected polarity are latched in an
//   edge-capture register, and any captured edge whose mask bit is set drives
//   a registered level interrupt towards the Nios II.
//
// Register map (word addressed, bits at and above WIDTH read as 0):
//   0  DATA      RO    debounced input state
//   1  reserved  RO    reads 0
//   2  IRQ_MASK  RW    per-bit interrupt enable
//   3  EDGE_CAP  W1C   captured edges, writing 1 clears the bit
//
// Ports:
//   clk        system clock
//   reset_n    asynchronous active-low reset
//   bus        Avalon-MM slave bundle (address, chipselect, write_n,
//              writedata, readdata with one clock read latency)
//   in_port    raw asynchronous switch/key inputs, WIDTH bits
//   irq        level interrupt, registered
//
// Parameters:
//   WIDTH         number of input bits (1..32)
//   EDGE_TYPE     0 rising, 1 falling, 2 any edge captured
//   DEBOUNCE_DIV  clocks per debounce sample tick (>= 1)
//   STABLE_TICKS  consecutive disagreeing ticks needed to accept a new level
//   IDLE_LEVEL    reset level of the synchronizer, debounced and previous state
// ---------------------------------------------------------------------------
module nios_system_de2_pio_switch_in #(
    parameter int WIDTH        = 18,
    parameter int EDGE_TYPE    = 0,
    parameter int DEBOUNCE_DIV = 50000,
    parameter int STABLE_TICKS = 3,
    parameter int IDLE_LEVEL   = 0
) (
    input  logic                           clk,
    input  logic                           reset_n,
    nios_system_de2_pio_switch_in_if.slave bus,
    input  logic [WIDTH-1:0]               in_port,
    output logic                           irq
);

    // Counter widths never collapse below one bit, so DEBOUNCE_DIV=1 and
    // STABLE_TICKS=1 still produce legal (constant-zero) counters.
    localparam int PRE_W = (DEBOUNCE_DIV > 1) ? $clog2(DEBOUNCE_DIV) : 1;
    localparam int CNT_W = (STABLE_TICKS > 1) ? $clog2(STABLE_TICKS) : 1;

    localparam logic [WIDTH-1:0] IDLE_VEC = (IDLE_LEVEL != 0) ? {WIDTH{1'b1}} : {WIDTH{1'b0}};
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(DEBOUNCE_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_TICKS - 1);

    localparam logic [1:0] ADDR_DATA     = 2'd0;
    localparam logic [1:0] ADDR_IRQ_MASK = 2'd2;
    localparam logic [1:0] ADDR_EDGE_CAP = 2'd3;

    logic [WIDTH-1:0] r_sync1;
    logic [WIDTH-1:0] r_sync2;
    logic [PRE_W-1:0] r_prescale;
    logic [CNT_W-1:0] r_cnt [WIDTH];
    logic [WIDTH-1:0] r_deb;
    logic [WIDTH-1:0] r_prev;
    logic [WIDTH-1:0] r_edge_cap;
    logic [WIDTH-1:0] r_irq_mask;
    logic             r_irq;
    logic [31:0]      r_readdata;

    logic             w_tick;
    logic             w_read;
    logic             w_write;
    logic             w_wr_mask;
    logic             w_wr_clear;
    logic [WIDTH-1:0] w_clear;
    logic [WIDTH-1:0] w_rise;
    logic [WIDTH-1:0] w_fall;
    logic [WIDTH-1:0] w_edge;
    logic [31:0]      w_rdata;
    logic             w_unused_wdata;

    // Bus decode: a read is any selected cycle with write_n high.
    assign w_read     = bus.chipselect &  bus.write_n;
    assign w_write    = bus.chipselect & ~bus.write_n;
    assign w_wr_mask  = w_write & (bus.address == ADDR_IRQ_MASK);
    assign w_wr_clear = w_write & (bus.address == ADDR_EDGE_CAP);
    assign w_clear    = w_wr_clear ? bus.writedata[WIDTH-1:0] : '0;

    // Write data bits above WIDTH have no register behind them.
    assign w_unused_wdata = ^bus.writedata;

    // Two-flop synchronizer; the raw pins are asynchronous to clk.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_sync1 <= IDLE_VEC;
            r_sync2 <= IDLE_VEC;
        end else begin
            r_sync1 <= in_port;
            r_sync2 <= r_sync1;
        end
    end

    // Free-running prescaler; the tick fires in the last count of each period.
    assign w_tick = (r_prescale == PRE_LAST);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_prescale <= '0;
        end else if (w_tick) begin
            r_prescale <= '0;
        end else begin
            r_prescale <= r_prescale + PRE_W'(1);
        end
    end

    // Per-bit debouncer: on each tick a bit whose synchronized value disagrees
    // with the debounced value advances its counter; any agreeing tick resets
    // the counter, so only STABLE_TICKS consecutive disagreeing ticks flip it.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_deb <= IDLE_VEC;
            for (int i = 0; i < WIDTH; i++) begin
                r_cnt[i] <= '0;
            end
        end else if (w_tick) begin
            for (int i = 0; i < WIDTH; i++) begin
                if (r_sync2[i] == r_deb[i]) begin
                    r_cnt[i] <= '0;
                end else if (r_cnt[i] == CNT_LAST) begin
                    r_deb[i] <= r_sync2[i];
                    r_cnt[i] <= '0;
                end else begin
                    r_cnt[i] <= r_cnt[i] + CNT_W'(1);
                end
            end
        end
    end

    // Previous debounced state; it resets to the same idle level as r_deb so
    // leaving reset never looks like an edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_prev <= IDLE_VEC;
        end else begin
            r_prev <= r_deb;
        end
    end

    assign w_rise = r_deb & ~r_prev;
    assign w_fall = ~r_deb & r_prev;

    // Edge polarity selection; anything other than 0 or 1 captures both.
    always_comb begin
        w_edge = '0;
        case (EDGE_TYPE)
            0:       w_edge = w_rise;
            1:       w_edge = w_fall;
            default: w_edge = w_rise | w_fall;
        endcase
    end

    // Edge capture: the OR with the new edge is applied after the clear so a
    // coincident edge and W1C leave the bit set and the edge is not lost.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_edge_cap <= '0;
        end else begin
            r_edge_cap <= (r_edge_cap & ~w_clear) | w_edge;
        end
    end

    // Interrupt mask register; masking never blocks capture, only the irq.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_irq_mask <= '0;
        end else if (w_wr_mask) begin
            r_irq_mask <= bus.writedata[WIDTH-1:0];
        end
    end

    // Registered interrupt, one clock behind capture or mask changes.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_irq <= 1'b0;
        end else begin
            r_irq <= |(r_edge_cap & r_irq_mask);
        end
    end

    // Read mux, zero-extended to the 32-bit bus; the reserved word reads 0.
    always_comb begin
        w_rdata = '0;
        case (bus.address)
            ADDR_DATA:     w_rdata[WIDTH-1:0] = r_deb;
            ADDR_IRQ_MASK: w_rdata[WIDTH-1:0] = r_irq_mask;
            ADDR_EDGE_CAP: w_rdata[WIDTH-1:0] = r_edge_cap;
            default:       w_rdata = '0;
        endcase
    end

    // Read data register: updates only on a read and otherwise holds.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_readdata <= '0;
        end else if (w_read) begin
            r_readdata <= w_rdata;
        end
    end

    assign bus.readdata = r_readdata;
    assign irq          = r_irq;

endmodule

// File: tb/tb_nios_system_de2_pio_switch_in.sv
// ---------------------------------------------------------------------------
// tb_nios_system_de2_pio_switch_in
//
// Bench for the switch input PIO with WIDTH=4, rising edges, DEBOUNCE_DIV=4,
// STABLE_TICKS=3 and IDLE_LEVEL=0. A behavioural reference model runs
// alongside the DUT and is used for the randomized traffic phase and for
// timing the coincident edge/clear scenario.
// ---------------------------------------------------------------------------
module tb_nios_system_de2_pio_switch_in;

    localparam int W   = 4;
    localparam int DIV = 4;
    localparam int ST  = 3;

    logic         clk = 1'b0;
    logic         reset_n;
    logic [W-1:0] in_port;
    logic         irq;

    int total = 0;
    int bad   = 0;

    nios_system_de2_pio_switch_in_if bus ();

    nios_system_de2_pio_switch_in #(
        .WIDTH        (W),
        .EDGE_TYPE    (0),
        .DEBOUNCE_DIV (DIV),
        .STABLE_TICKS (ST),
        .IDLE_LEVEL   (0)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus),
        .in_port (in_port),
        .irq     (irq)
    );

    // 100 MHz-style free running clock; inputs change on the falling edge.
    always #5 clk = ~clk;

    // Reference model state. The debouncer is described as "how many ticks in
    // a row has the synchronized input disagreed with the accepted level",
    // and the synchronizer as a two-deep history of the raw input.
    logic [W-1:0] mS1, mS2, mDeb, mPrev, mCap, mMask, mEdges, mClr;
    int           mRun [W];
    int           mPre;
    logic         mIrq;
    logic [31:0]  mRd;

    function automatic void modelReset();
        mS1   = '0;
        mS2   = '0;
        mDeb  = '0;
        mPrev = '0;
        mCap  = '0;
        mMask = '0;
        mPre  = 0;
        mIrq  = 1'b0;
        mRd   = '0;
        for (int i = 0; i < W; i++) mRun[i] = 0;
    endfunction

    // One clock of the model; every register-visible value is computed from
    // the state before this clock.
    function automatic void modelStep();
        bit isTick;
        isTick = (mPre == DIV - 1);
        mClr   = '0;
        if (bus.chipselect && bus.write_n) begin
            case (bus.address)
                2'd0:    mRd = {{(32-W){1'b0}}, mDeb};
                2'd2:    mRd = {{(32-W){1'b0}}, mMask};
                2'd3:    mRd = {{(32-W){1'b0}}, mCap};
                default: mRd = 32'h0;
            endcase
        end
        if (bus.chipselect && !bus.write_n && bus.address == 2'd3) mClr = bus.writedata[W-1:0];
        mIrq   = |(mCap & mMask);
        mEdges = mDeb & ~mPrev;
        mPrev  = mDeb;
        if (isTick) begin
            for (int i = 0; i < W; i++) begin
                if (mS2[i] != mDeb[i]) begin
                    mRun[i] = mRun[i] + 1;
                    if (mRun[i] == ST) begin
                        mDeb[i] = mS2[i];
                        mRun[i] = 0;
                    end
                end else begin
                    mRun[i] = 0;
                end
            end
        end
        mCap = (mCap & ~mClr) | mEdges;
        if (bus.chipselect && !bus.write_n && bus.address == 2'd2) mMask = bus.writedata[W-1:0];
        mS2  = mS1;
        mS1  = in_port;
        mPre = isTick ? 0 : mPre + 1;
    endfunction

    // The model follows the same clock and asynchronous reset as the DUT.
    initial begin
        modelReset();
        forever begin
            @(posedge clk or negedge reset_n);
            if (!reset_n) modelReset();
            else modelStep();
        end
    end

    // Single-cycle bus write, entered and left on a falling edge.
    task automatic busWrite(input logic [1:0] a, input logic [31:0] d);
        bus.address    = a;
        bus.writedata  = d;
        bus.chipselect = 1'b1;
        bus.write_n    = 1'b0;
        @(posedge clk);
        @(negedge clk);
        bus.chipselect = 1'b0;
        bus.write_n    = 1'b1;
    endtask

    // Single-cycle bus read; readdata is sampled on the following falling edge.
    task automatic busRead(input logic [1:0] a, output logic [31:0] d);
        bus.address    = a;
        bus.chipselect = 1'b1;
        bus.write_n    = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.chipselect = 1'b0;
        d = bus.readdata;
    endtask

    // Reset state: readdata and irq low during reset, all registers read 0.
    task automatic test_reset();
        logic [31:0] rd;
        reset_n        = 1'b1;
        in_port        = '0;
        bus.address    = 2'd0;
        bus.chipselect = 1'b0;
        bus.write_n    = 1'b1;
        bus.writedata  = '0;
        #2 reset_n = 1'b0;
        repeat (3) @(negedge clk);
        total++;
        if (bus.readdata !== 32'h0) begin
            bad++;
            $display("[TB] FAIL reset_readdata: got %h expected %h", bus.readdata, 32'h0);
        end
        total++;
        if (irq !== 1'b0) begin
            bad++;
            $display("[TB] FAIL reset_irq: got %b expected 0", irq);
        end
        reset_n = 1'b1;
        @(negedge clk);
        busRead(2'd0, rd);
        total++;
        if (rd !== 32'h0) begin bad++; $display("[TB] FAIL reset_data: got %h expected %h", rd, 32'h0); end
        busRead(2'd2, rd);
        total++;
        if (rd !== 32'h0) begin bad++; $display("[TB] FAIL reset_mask: got %h expected %h", rd, 32'h0); end
        busRead(2'd3, rd);
        total++;
        if (rd !== 32'h0) begin bad++; $display("[TB] FAIL reset_edgecap: got %h expected %h", rd, 32'h0); end
    endtask

    // A held input reaches DATA within 2 sync + 3*4 debounce + 1 read clocks.
    task automatic test_debounce_rise();
        logic [31:0] rd;
        int n;
        in_port = 4'b0001;
        rd = '0;
        n  = 0;
        while (rd !== 32'h1 && n < 30) begin
            busRead(2'd0, rd);
            n++;
        end
        total++;
        if (rd !== 32'h1 || n > 15) begin
            bad++;
            $display("[TB] FAIL rise_latency: got data %h after %0d clks, required 1 within 15", rd, n);
        end
        repeat (2) @(negedge clk);
        busRead(2'd3, rd);
        total++;
        if (rd !== 32'h1) begin bad++; $display("[TB] FAIL rise_edgecap: got %h expected %h", rd, 32'h1); end
        total++;
        if (irq !== 1'b0) begin bad++; $display("[TB] FAIL rise_irq_masked: got %b expected 0", irq); end
    endtask

    // Unmasking a captured edge raises irq a clock later; W1C drops it again.
    task automatic test_irq_mask();
        logic [31:0] rd;
        busWrite(2'd2, 32'h1);
        total++;
        if (irq !== 1'b0) begin bad++; $display("[TB] FAIL mask_irq_same_clk: got %b expected 0", irq); end
        @(negedge clk);
        total++;
        if (irq !== 1'b1) begin bad++; $display("[TB] FAIL mask_irq_next_clk: got %b expected 1", irq); end
        busWrite(2'd3, 32'h1);
        total++;
        if (irq !== 1'b1) begin bad++; $display("[TB] FAIL clear_irq_same_clk: got %b expected 1", irq); end
        @(negedge clk);
        total++;
        if (irq !== 1'b0) begin bad++; $display("[TB] FAIL clear_irq_next_clk: got %b expected 0", irq); end
        busRead(2'd2, rd);
        total++;
        if (rd !== 32'h1) begin bad++; $display("[TB] FAIL mask_readback: got %h expected %h", rd, 32'h1); end
        busRead(2'd3, rd);
        total++;
        if (rd !== 32'h0) begin bad++; $display("[TB] FAIL clear_readback: got %h expected %h", rd, 32'h0); end
    endtask

    // A 6-clock pulse spans at most two ticks, so it never reaches DATA.
    task automatic test_glitch();
        logic [31:0] rd;
        in_port = 4'b0011;
        repeat (6) @(negedge clk);
        in_port = 4'b0001;
        repeat (20) @(negedge clk);
        busRead(2'd0, rd);
        total++;
        if (rd !== 32'h1) begin bad++; $display("[TB] FAIL glitch_data: got %h expected %h", rd, 32'h1); end
        busRead(2'd3, rd);
        total++;
        if (rd !== 32'h0) begin bad++; $display("[TB] FAIL glitch_edgecap: got %h expected %h", rd, 32'h0); end
    endtask

    // W1C of bit 2 lands on the same clock as its rising-edge pulse.
    task automatic test_set_wins();
        logic [31:0] rd;
        int waitCnt;
        in_port = 4'b0101;
        waitCnt = 0;
        while (!(mDeb[2] && !mPrev[2]) && waitCnt < 40) begin
            @(negedge clk);
            waitCnt++;
        end
        total++;
        if (waitCnt >= 40) begin
            bad++;
            $display("[TB] FAIL set_wins_timeout: waited %0d clks, required edge within 40", waitCnt);
        end else begin
            busWrite(2'd3, 32'h4);
            busRead(2'd3, rd);
            total++;
            if (rd !== 32'h4) begin bad++; $display("[TB] FAIL set_wins_edgecap: got %h expected %h", rd, 32'h4); end
            total++;
            if (irq !== 1'b0) begin bad++; $display("[TB] FAIL set_wins_irq: got %b expected 0", irq); end
        end
    endtask

    // Reset in the middle of a debounce window; afterwards a full new window
    // of three ticks is needed before DATA shows the held input.
    task automatic test_reset_mid();
        logic [31:0] rd;
        in_port = 4'hF;
        repeat (6) @(negedge clk);
        reset_n = 1'b0;
        #1;
        total++;
        if (bus.readdata !== 32'h0) begin bad++; $display("[TB] FAIL midreset_readdata: got %h expected %h", bus.readdata, 32'h0); end
        total++;
        if (irq !== 1'b0) begin bad++; $display("[TB] FAIL midreset_irq: got %b expected 0", irq); end
        @(negedge clk);
        reset_n = 1'b1;
        busRead(2'd2, rd);
        total++;
        if (rd !== 32'h0) begin bad++; $display("[TB] FAIL midreset_mask: got %h expected %h", rd, 32'h0); end
        busRead(2'd3, rd);
        total++;
        if (rd !== 32'h0) begin bad++; $display("[TB] FAIL midreset_edgecap: got %h expected %h", rd, 32'h0); end
        busRead(2'd0, rd);
        total++;
        if (rd !== 32'h0) begin bad++; $display("[TB] FAIL midreset_data_early: got %h expected %h", rd, 32'h0); end
        repeat (6) @(negedge clk);
        busRead(2'd0, rd);
        total++;
        if (rd !== 32'h0) begin bad++; $display("[TB] FAIL midreset_data_window: got %h expected %h", rd, 32'h0); end
        repeat (4) @(negedge clk);
        busRead(2'd0, rd);
        total++;
        if (rd !== 32'hF) begin bad++; $display("[TB] FAIL midreset_data_late: got %h expected %h", rd, 32'hF); end
        repeat (3) @(negedge clk);
        busRead(2'd3, rd);
        total++;
        if (rd !== 32'hF) begin bad++; $display("[TB] FAIL midreset_edgecap_late: got %h expected %h", rd, 32'hF); end
    endtask

    // Random inputs held for random lengths plus random single-cycle bus
    // traffic, compared against the model on every clock.
    task automatic test_random();
        int hold;
        int op;
        hold = 0;
        for (int c = 0; c < 1500; c++) begin
            if (hold == 0) begin
                in_port = W'($urandom);
                hold    = $urandom_range(0, 20);
            end else begin
                hold--;
            end
            op = $urandom_range(0, 9);
            bus.chipselect = (op != 9);
            bus.write_n    = (op <= 5);
            bus.writedata  = $urandom;
            if (op <= 5)      bus.address = 2'($urandom_range(0, 3));
            else if (op == 6) bus.address = 2'd2;
            else if (op == 7) bus.address = 2'd3;
            else              bus.address = 2'($urandom_range(0, 1));
            @(negedge clk);
            total++;
            if (bus.readdata !== mRd) begin
                bad++;
                $display("[TB] FAIL random_readdata clk %0d: got %h expected %h", c, bus.readdata, mRd);
            end
            total++;
            if (irq !== mIrq) begin
                bad++;
                $display("[TB] FAIL random_irq clk %0d: got %b expected %b", c, irq, mIrq);
            end
        end
        bus.chipselect = 1'b0;
        bus.write_n    = 1'b1;
    endtask

    // Scenario sequence; each task leaves the bus idle on a falling edge.
    initial begin
        $display("[TB] starting switch input PIO bench");
        test_reset();
        test_debounce_rise();
        test_irq_mask();
        test_glitch();
        test_set_wins();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
